mem_port_arbiter: RTL and testbench

- Shares the single data-memory port between instruction fetch (I) and the data cache miss/write path (D).
- Sits between the fetch stage / CACHE block and data memory.
- Sequences each access as a request/ack transaction, with round-robin priority, a stall output for the pipeline and a memory-timeout guard.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/arb_timeout_ctr.sv | 35 +++
 rtl/mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter.
// Contents:
//   arb_state_t : FSM state encoding (IDLE / BUSY / DONE)
//   owner_t     : which requester owns the memory port (I = fetch, D = data)
//   sat_inc32   : saturating 32-bit increment, used by the optional
//                 performance counters (MEM_ARB_PERF_EN)
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Cycle counter that flags when an enabled wait has lasted TIMEOUT cycles.
// Ports:
//   clk    : clock
//   srst   : synchronous active-high reset, clears the count
//   clear  : synchronous clear (takes effect at the next edge)
//   enable : count this cycle; the count holds at TIMEOUT-1 once reached
//   expire : combinational, high during the TIMEOUT-th enabled cycle
// Parameter TIMEOUT: 1..255.
module arb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_reg;

  // cnt_reg counts enabled cycles already completed, so the first enabled
  // cycle sees 0 and the TIMEOUT-th sees TIMEOUT-1.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      cnt_reg <= '0;
    end else if (enable && (cnt_reg != LAST)) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  assign expire = enable && (cnt_reg == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and the data side (D).
// Each access is IDLE -> BUSY (mem_req held until mem_ack or timeout) -> DONE
// (owner's ack pulses, one-cycle gap) -> IDLE. Round-robin when both request.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   i_req/i_addr            : fetch request in; i_ack/i_rdata out
//   d_req/d_we/d_addr/d_wdata : data request in; d_ack/d_rdata out
//   mem_req/mem_we/mem_addr/mem_wdata : memory request out
//   mem_rdata/mem_ack       : memory response in
//   stall                   : combinational pipeline stall
//   err                     : one-cycle pulse on a timeout abort
// Optional: define MEM_ARB_PERF_EN to add saturating 32-bit counters
//   i_grant_cnt, d_grant_cnt, conflict_cnt, timeout_cnt as extra outputs.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              err
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       i_grant_cnt,
  output logic [31:0]       d_grant_cnt,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       timeout_cnt
`endif
);

  arb_state_t state_reg, state_next;
  owner_t     owner_reg, owner_next;
  owner_t     last_grant_reg, last_grant_next;
  owner_t     grant_owner;
  logic       grant_valid;
  logic       to_expire;

  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DATA_W-1:0] i_rdata_reg, i_rdata_next;
  logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;
  logic              i_ack_reg, i_ack_next;
  logic              d_ack_reg, d_ack_next;
  logic              err_reg, err_next;

  arb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clock),
    .srst   (reset),
    .clear  (state_reg != ARB_BUSY),
    .enable (state_reg == ARB_BUSY),
    .expire (to_expire)
  );

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ARB_IDLE;
      owner_reg      <= OWN_I;
      last_grant_reg <= OWN_I;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      i_rdata_reg    <= '0;
      d_rdata_reg    <= '0;
      i_ack_reg      <= 1'b0;
      d_ack_reg      <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      i_rdata_reg    <= i_rdata_next;
      d_rdata_reg    <= d_rdata_next;
      i_ack_reg      <= i_ack_next;
      d_ack_reg      <= d_ack_next;
      err_reg        <= err_next;
    end
  end

  // Next state and grant decision.
  always_comb begin
    state_next  = state_reg;
    grant_valid = 1'b0;
    grant_owner = OWN_I;
    case (state_reg)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          grant_valid = 1'b1;
          if (i_req && d_req) begin
            grant_owner = (last_grant_reg == OWN_I) ? OWN_D : OWN_I;
          end else begin
            grant_owner = d_req ? OWN_D : OWN_I;
          end
          state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (mem_ack || to_expire) begin
          state_next = ARB_DONE;
        end
      end
      ARB_DONE: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    mem_req_next    = mem_req_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    i_rdata_next    = i_rdata_reg;
    d_rdata_next    = d_rdata_reg;
    i_ack_next      = 1'b0;
    d_ack_next      = 1'b0;
    err_next        = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (grant_valid) begin
          owner_next      = grant_owner;
          last_grant_next = grant_owner;
          mem_req_next    = 1'b1;
          if (grant_owner == OWN_D) begin
            mem_we_next    = d_we;
            mem_addr_next  = d_addr;
            mem_wdata_next = d_wdata;
          end else begin
            mem_we_next    = 1'b0;
            mem_addr_next  = i_addr;
            mem_wdata_next = '0;
          end
        end
      end
      ARB_BUSY: begin
        // mem_ack takes priority over a coincident timeout.
        if (mem_ack || to_expire) begin
          mem_req_next = 1'b0;
          err_next     = ~mem_ack;
          if (owner_reg == OWN_I) begin
            i_ack_next   = 1'b1;
            i_rdata_next = mem_ack ? mem_rdata : '0;
          end else begin
            d_ack_next = 1'b1;
            // Stores never disturb d_rdata, even when aborted.
            if (!mem_we_reg) begin
              d_rdata_next = mem_ack ? mem_rdata : '0;
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign i_rdata   = i_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign i_ack     = i_ack_reg;
  assign d_ack     = d_ack_reg;
  assign err       = err_reg;
  assign stall     = (i_req | d_req) & ~(i_ack_reg | d_ack_reg);

`ifdef MEM_ARB_PERF_EN
  logic [31:0] i_grant_cnt_reg, d_grant_cnt_reg, conflict_cnt_reg, timeout_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      i_grant_cnt_reg  <= '0;
      d_grant_cnt_reg  <= '0;
      conflict_cnt_reg <= '0;
      timeout_cnt_reg  <= '0;
    end else begin
      if (grant_valid && (grant_owner == OWN_I)) i_grant_cnt_reg <= sat_inc32(i_grant_cnt_reg);
      if (grant_valid && (grant_owner == OWN_D)) d_grant_cnt_reg <= sat_inc32(d_grant_cnt_reg);
      if ((state_reg == ARB_IDLE) && i_req && d_req) conflict_cnt_reg <= sat_inc32(conflict_cnt_reg);
      if ((state_reg == ARB_BUSY) && to_expire && !mem_ack) timeout_cnt_reg <= sat_inc32(timeout_cnt_reg);
    end
  end

  assign i_grant_cnt  = i_grant_cnt_reg;
  assign d_grant_cnt  = d_grant_cnt_reg;
  assign conflict_cnt = conflict_cnt_reg;
  assign timeout_cnt  = timeout_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          stall;
  logic          err;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   i_grant_cnt, d_grant_cnt, conflict_cnt, timeout_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall     (stall),
    .err       (err)
`ifdef MEM_ARB_PERF_EN
    ,
    .i_grant_cnt  (i_grant_cnt),
    .d_grant_cnt  (d_grant_cnt),
    .conflict_cnt (conflict_cnt),
    .timeout_cnt  (timeout_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reference state: memory contents, expected rdata outputs, round-robin
  // history and event counts, all derived from the access rules.
  logic [DW-1:0] mem_model [0:255];
  logic [DW-1:0] i_rd_exp, d_rd_exp;
  bit            last_d;
  int            m_igrant, m_dgrant, m_conf, m_tout;

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check_eq({tag, "_i_ack"}, 32'(i_ack), 32'd0);
    check_eq({tag, "_d_ack"}, 32'(d_ack), 32'd0);
    check_eq({tag, "_i_rdata"}, 32'(i_rdata), 32'd0);
    check_eq({tag, "_d_rdata"}, 32'(d_rdata), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    bit            own_d, do_rst, aborted, timed_out;
    int            k;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    logic [DW-1:0] exp_wd;

    for (int a = 0; a < 256; a++) mem_model[a] = 16'($urandom);
    i_rd_exp = '0;
    d_rd_exp = '0;
    last_d   = 1'b0;
    m_igrant = 0; m_dgrant = 0; m_conf = 0; m_tout = 0;

    reset = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();
    check_eq("idle_stall", 32'(stall), 32'd0);
    check_eq("idle_mem_req", 32'(mem_req), 32'd0);

    for (int t = 0; t < 80; t++) begin
      // Raise new requests on idle sides; at least one side must be pending.
      if (!i_req && ($urandom_range(0, 1) == 1)) begin
        i_req  = 1'b1;
        i_addr = 16'($urandom);
      end
      if (!d_req && (($urandom_range(0, 1) == 1) || !i_req)) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 16'($urandom);
        d_wdata = 16'($urandom);
      end
      #1;
      check_eq("stall_pending", 32'(stall), 32'd1);

      own_d = (i_req && d_req) ? !last_d : d_req;
      if (i_req && d_req) m_conf++;
      if (own_d) begin
        exp_addr = d_addr; exp_we = d_we; exp_wd = d_wdata; m_dgrant++;
      end else begin
        exp_addr = i_addr; exp_we = 1'b0; exp_wd = '0; m_igrant++;
      end
      last_d = own_d;
      do_rst = ($urandom_range(0, 11) == 0);
      k      = do_rst ? 99 : $urandom_range(0, 5);

      tick();
      $display("[TB] txn %0d owner=%s we=%0d addr=%h delay=%0d rst=%0d",
               t, own_d ? "D" : "I", exp_we, exp_addr, k, do_rst);
      check_eq("grant_mem_req", 32'(mem_req), 32'd1);
      check_eq("grant_mem_addr", 32'(mem_addr), 32'(exp_addr));
      check_eq("grant_mem_we", 32'(mem_we), 32'(exp_we));
      check_eq("grant_mem_wdata", 32'(mem_wdata), 32'(exp_wd));

      aborted   = 1'b0;
      timed_out = 1'b0;
      for (int j = 0; j < TO; j++) begin
        // Requester may withdraw mid-access; the access still completes.
        if (j == 0 && !do_rst && ($urandom_range(0, 3) == 0)) begin
          if (own_d) d_req = 1'b0; else i_req = 1'b0;
        end
        if (do_rst && j == 1) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
          aborted = 1'b1;
          break;
        end
        if (j == k) begin
          mem_ack   = 1'b1;
          mem_rdata = exp_we ? 16'($urandom) : mem_model[exp_addr[7:0]];
          tick();
          mem_ack   = 1'b0;
          break;
        end
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        tick();
        if (j == TO - 1) begin
          timed_out = 1'b1;
          break;
        end
        check_eq("busy_mem_req", 32'(mem_req), 32'd1);
        check_eq("busy_mem_addr", 32'(mem_addr), 32'(exp_addr));
        check_eq("busy_mem_we", 32'(mem_we), 32'(exp_we));
        check_eq("busy_mem_wdata", 32'(mem_wdata), 32'(exp_wd));
        check_eq("busy_no_ack", 32'({i_ack, d_ack, err}), 32'd0);
      end

      if (aborted) begin
        check_all_zero("midrst");
        i_rd_exp = '0; d_rd_exp = '0; last_d = 1'b0;
        m_igrant = 0; m_dgrant = 0; m_conf = 0; m_tout = 0;
        continue;
      end

      // Owner's completion cycle.
      if (timed_out) begin
        m_tout++;
        if (!own_d) i_rd_exp = '0;
        else if (!exp_we) d_rd_exp = '0;
      end else begin
        if (!own_d) i_rd_exp = mem_model[exp_addr[7:0]];
        else if (!exp_we) d_rd_exp = mem_model[exp_addr[7:0]];
        else mem_model[exp_addr[7:0]] = exp_wd;
      end
      check_eq("done_i_ack", 32'(i_ack), 32'(!own_d));
      check_eq("done_d_ack", 32'(d_ack), 32'(own_d));
      check_eq("done_err", 32'(err), 32'(timed_out));
      check_eq("done_i_rdata", 32'(i_rdata), 32'(i_rd_exp));
      check_eq("done_d_rdata", 32'(d_rdata), 32'(d_rd_exp));
      check_eq("done_mem_req", 32'(mem_req), 32'd0);
      check_eq("done_stall", 32'(stall), 32'd0);

      if (own_d) d_req = 1'b0; else i_req = 1'b0;
      tick();
      check_eq("gap_acks", 32'({i_ack, d_ack, err}), 32'd0);
      check_eq("gap_mem_req", 32'(mem_req), 32'd0);
      check_eq("gap_stall", 32'(stall), 32'(i_req | d_req));
      check_eq("gap_i_rdata", 32'(i_rdata), 32'(i_rd_exp));
      check_eq("gap_d_rdata", 32'(d_rdata), 32'(d_rd_exp));
    end

`ifdef MEM_ARB_PERF_EN
    check_eq("perf_i_grant", i_grant_cnt, 32'(m_igrant));
    check_eq("perf_d_grant", d_grant_cnt, 32'(m_dgrant));
    check_eq("perf_conflict", conflict_cnt, 32'(m_conf));
    check_eq("perf_timeout", timeout_cnt, 32'(m_tout));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
